idct_transpose_buffer: RTL and testbench



---
 rtl/idct_transpose_buffer.sv | 157 +++++++++++++++
 tb/tb_idct_transpose_buffer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/idct_transpose_buffer.sv
// idct_transpose_buffer
//   Collects eight row-IDCT output rows into an 8x8 block and re-emits it one
//   column per cycle for the column IDCT pass. Two banks are used in ping-pong
//   fashion so that a continuous row stream yields a continuous column stream.
// Ports:
//   clk        clock
//   rst        synchronous reset, active-high
//   valid_in   row_in holds a valid row this cycle
//   row_in     8 signed samples, index j = column position
//   valid_out  col_out holds a valid column (registered)
//   col_out    8 signed samples, index i = source row (registered, 0 when idle)
//   col_last   marks the 8th column of a block (registered)
//   overflow   sticky: a row arrived for a bank still pending read
module idct_transpose_buffer #(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_in,
  input  logic signed [DATA_WIDTH-1:0] row_in  [7:0],
  output logic                         valid_out,
  output logic signed [DATA_WIDTH-1:0] col_out [7:0],
  output logic                         col_last,
  output logic                         overflow
);

  localparam int unsigned N     = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic               wr_bank_q, wr_bank_d;
  logic [IDX_W-1:0]   row_cnt_q, row_cnt_d;
  logic [1:0]         full_q, full_d;
  logic               overflow_q, overflow_d;
  logic               rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0]   col_cnt_q, col_cnt_d;

  logic                         valid_q, valid_d;
  logic                         last_q, last_d;
  logic signed [DATA_WIDTH-1:0] col_q [N-1:0];
  logic signed [DATA_WIDTH-1:0] col_d [N-1:0];

  // Bank storage: [bank][row][column]; contents are never reset.
  logic signed [DATA_WIDTH-1:0] mem_q [1:0][N-1:0][N-1:0];

  logic               wr_accept_c;
  logic               wr_done_c;
  logic               rd_active_c;
  logic               rd_done_c;
  logic [IDX_W-1:0]   rd_col_c;

  // Write-side acceptance: rows aimed at a bank still awaiting read are dropped.
  always_comb begin
    wr_accept_c = valid_in && !full_q[wr_bank_q];
    wr_done_c   = wr_accept_c && (row_cnt_q == IDX_W'(N - 1));
  end

  // Reader state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Reader next state. Column 0 is emitted on the IDLE->READ edge, so READ
  // always covers columns 1..7 (and column 0 of a directly following bank).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (full_q[rd_bank_q]) state_d = READ;
      READ: if ((col_cnt_q == IDX_W'(N - 1)) && !full_q[!rd_bank_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reader outputs: which column is read this edge and the output payload.
  always_comb begin
    rd_active_c = 1'b0;
    rd_col_c    = '0;
    unique case (state_q)
      IDLE: rd_active_c = full_q[rd_bank_q];
      READ: begin
        rd_active_c = 1'b1;
        rd_col_c    = col_cnt_q;
      end
      default: rd_active_c = 1'b0;
    endcase
    rd_done_c = rd_active_c && (rd_col_c == IDX_W'(N - 1));
    valid_d   = rd_active_c;
    last_d    = rd_done_c;
    for (int i = 0; i < N; i++) begin
      col_d[i] = rd_active_c ? mem_q[rd_bank_q][i][rd_col_c] : '0;
    end
  end

  // Bank bookkeeping. A filling bank and a releasing bank are always distinct
  // (filling needs full=0, reading needs full=1), so set and clear never collide.
  always_comb begin
    row_cnt_d  = row_cnt_q;
    wr_bank_d  = wr_bank_q;
    full_d     = full_q;
    overflow_d = overflow_q;
    rd_bank_d  = rd_bank_q;
    col_cnt_d  = col_cnt_q;
    if (valid_in && full_q[wr_bank_q]) overflow_d = 1'b1;
    if (wr_accept_c) row_cnt_d = row_cnt_q + IDX_W'(1);
    if (wr_done_c) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = !wr_bank_q;
    end
    if (rd_active_c) col_cnt_d = rd_col_c + IDX_W'(1);
    if (rd_done_c) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = !rd_bank_q;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_q  <= 1'b0;
      row_cnt_q  <= '0;
      full_q     <= '0;
      overflow_q <= 1'b0;
      rd_bank_q  <= 1'b0;
      col_cnt_q  <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      col_q      <= '{default: '0};
    end else begin
      wr_bank_q  <= wr_bank_d;
      row_cnt_q  <= row_cnt_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
      rd_bank_q  <= rd_bank_d;
      col_cnt_q  <= col_cnt_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      col_q      <= col_d;
    end
  end

  // Row storage write.
  always_ff @(posedge clk) begin
    if (wr_accept_c) mem_q[wr_bank_q][row_cnt_q] <= row_in;
  end

  assign valid_out = valid_q;
  assign col_last  = last_q;
  assign col_out   = col_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_idct_transpose_buffer.sv
// tb_idct_transpose_buffer
//   Directed bench for idct_transpose_buffer. Rows are driven shortly after
//   each rising edge; a block model pushes the eight expected columns, with
//   the cycle each must appear on, into a scoreboard queue that a falling-edge
//   monitor pops and compares.
module tb_idct_transpose_buffer;

  localparam int unsigned DW = 64;

  typedef logic [7:0][DW-1:0] row_t;
  typedef struct packed {
    row_t        d;
    logic        last;
    logic [31:0] due;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 valid_in = 1'b0;
  logic signed [DW-1:0] row_in  [7:0];
  logic                 valid_out;
  logic signed [DW-1:0] col_out [7:0];
  logic                 col_last;
  logic                 overflow;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] cyc = '0;

  exp_t sb [$];
  row_t mblk [8];
  int   mrow = 0;

  idct_transpose_buffer #(.DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .row_in    (row_in),
    .valid_out (valid_out),
    .col_out   (col_out),
    .col_last  (col_last),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  function automatic row_t pat(input int base, input int i);
    row_t r;
    for (int j = 0; j < 8; j++) r[j] = 64'(base + 8 * i + j);
    return r;
  endfunction

  function automatic row_t extreme(input int i);
    row_t r;
    for (int j = 0; j < 8; j++) begin
      case ((i + j) % 3)
        0:       r[j] = 64'hFFFF_FFFF_FFFF_FFFF;
        1:       r[j] = 64'h8000_0000_0000_0000;
        default: r[j] = 64'h7FFF_FFFF_FFFF_FFFF;
      endcase
    end
    return r;
  endfunction

  // Drive one row; on the 8th row queue the transposed columns with due cycles.
  task automatic send_row(input row_t r);
    exp_t e;
    @(posedge clk); #1;
    valid_in = 1'b1;
    for (int j = 0; j < 8; j++) row_in[j] = r[j];
    mblk[mrow] = r;
    mrow++;
    if (mrow == 8) begin
      mrow = 0;
      for (int c = 0; c < 8; c++) begin
        for (int i = 0; i < 8; i++) e.d[i] = mblk[i][c];
        e.last = (c == 7);
        e.due  = cyc + 32'd2 + 32'(c);
        sb.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      valid_in = 1'b0;
    end
  endtask

  // Columns already on the output stay expected; later ones are discarded.
  task automatic do_reset();
    @(posedge clk); #1;
    rst      = 1'b1;
    valid_in = 1'b0;
    while (sb.size() > 0 && sb[$].due > cyc) void'(sb.pop_back());
    mrow = 0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 40 && sb.size() != 0; t++) idle(1);
    idle(2);
    checks++;
    assert (sb.size() == 0)
      else begin errors++; $error("FAIL drain_timeout pending=%0d required=0", sb.size()); end
  endtask

  // Output monitor on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst || cyc > 32'd1) begin
      checks++;
      assert (overflow === 1'b0)
        else begin errors++; $error("FAIL overflow observed=%b expected=0", overflow); end
      if (valid_out === 1'b1) begin
        checks++;
        assert (sb.size() > 0)
          else begin errors++; $error("FAIL unexpected_col cyc=%0d observed valid_out=1 expected 0", cyc); end
        if (sb.size() > 0) begin
          e = sb.pop_front();
          checks++;
          assert (cyc === e.due)
            else begin errors++; $error("FAIL col_timing observed cyc=%0d expected cyc=%0d", cyc, e.due); end
          checks++;
          assert (col_last === e.last)
            else begin errors++; $error("FAIL col_last observed=%b expected=%b", col_last, e.last); end
          for (int i = 0; i < 8; i++) begin
            checks++;
            assert (col_out[i] === signed'(e.d[i]))
              else begin errors++; $error("FAIL col_data i=%0d observed=%h expected=%h", i, col_out[i], e.d[i]); end
          end
        end
      end else begin
        checks++;
        assert (valid_out === 1'b0)
          else begin errors++; $error("FAIL valid_out observed=%b expected=0", valid_out); end
        checks++;
        assert (col_last === 1'b0)
          else begin errors++; $error("FAIL idle_last observed=%b expected=0", col_last); end
        for (int i = 0; i < 8; i++) begin
          checks++;
          assert (col_out[i] === '0)
            else begin errors++; $error("FAIL idle_zero i=%0d observed=%h expected=0", i, col_out[i]); end
        end
        checks++;
        assert (!(sb.size() > 0 && sb[0].due <= cyc))
          else begin
            errors++;
            $error("FAIL missing_col cyc=%0d observed valid_out=0 expected column due %0d", cyc, sb[0].due);
            void'(sb.pop_front());
          end
      end
    end
  end

  initial begin
    for (int j = 0; j < 8; j++) row_in[j] = '0;
    void'($urandom(32'd17));

    // Reset state.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    assert (valid_out === 1'b0)
      else begin errors++; $error("FAIL reset_valid observed=%b expected=0", valid_out); end
    checks++;
    assert (col_out[3] === '0)
      else begin errors++; $error("FAIL reset_col observed=%h expected=0", col_out[3]); end

    // Single block.
    for (int i = 0; i < 8; i++) send_row(pat(0, i));
    drain();

    // Three blocks back-to-back.
    for (int b = 0; b < 3; b++)
      for (int i = 0; i < 8; i++) send_row(pat(1000 * (b + 1), i));
    drain();

    // Gappy input.
    for (int i = 0; i < 8; i++) begin
      idle(int'($urandom_range(0, 3)));
      send_row(pat(5000, i));
    end
    drain();

    // Signed extremes.
    for (int i = 0; i < 8; i++) send_row(extreme(i));
    drain();

    // Reset after five rows, then a fresh block.
    for (int i = 0; i < 5; i++) send_row(pat(7000, i));
    do_reset();
    for (int i = 0; i < 8; i++) send_row(pat(8000, i));
    drain();

    // Reset while column 4 is on the output, then a normal block.
    for (int i = 0; i < 8; i++) send_row(pat(9000, i));
    idle(5);
    do_reset();
    idle(3);
    for (int i = 0; i < 8; i++) send_row(pat(10000, i));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
